// File: rtl/core_ctrl_pkg.sv
// Shared opcode constants, state encoding and opcode classification helpers
// for the multi-cycle RV32I sequencer.
package core_ctrl_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    function automatic logic opc_writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic logic opc_is_mem(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic opc_is_legal(input logic [6:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL,
            OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the sequencer
// (master) and the memory system (slave).
interface core_ctrl_if;

    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/core_next_pc.sv
// Combinational next-PC selection and the AUIPC adder (pc + imm).
module core_next_pc
    import core_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic [6:0]  opcode,
    input  logic        take_branch,
    output logic [31:0] next_pc,
    output logic [31:0] auipc_sum
);

    logic [31:0] pc_imm_s;
    logic [31:0] pc_seq_s;
    logic [31:0] jalr_s;

    assign pc_imm_s  = pc + imm;
    assign pc_seq_s  = pc + 32'd4;
    assign jalr_s    = (rs1_val + imm) & 32'hFFFF_FFFE;
    assign auipc_sum = pc_imm_s;

    // Target select; all sums wrap silently mod 2^32.
    always_comb begin
        next_pc = pc_seq_s;
        case (opcode)
            OPC_JAL:  next_pc = pc_imm_s;
            OPC_JALR: next_pc = jalr_s;
            OPC_BRANCH: begin
                if (take_branch) begin
                    next_pc = pc_imm_s;
                end else begin
                    next_pc = pc_seq_s;
                end
            end
            default:  next_pc = pc_seq_s;
        endcase
    end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning pc, ir and instret.
// Optional illegal-opcode halt is enabled by defining RV_TRAP_EN.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    core_ctrl_if.master        bus,
    output logic [31:0]        pc,
    output logic [31:0]        ir,
    input  logic [31:0]        imm,
    input  logic [31:0]        rs1_val,
    input  logic [31:0]        alu_busc,
    input  logic               take_branch,
    output logic               rf_we,
    output logic [31:0]        rf_wdata,
    output logic [31:0]        instret,
    output logic               trap
);

    state_e      state_r;
    state_e      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic [31:0] instret_r;
    logic        imem_req_r;
    logic        dmem_req_r;
    logic        dmem_we_r;
    logic        rf_we_r;
    logic [31:0] rf_wdata_r;
    logic        br_taken_r;
    logic [6:0]  opcode_s;
    logic        fetch_done_s;
    logic        mem_done_s;
    logic [31:0] next_pc_s;
    logic [31:0] auipc_s;

    assign opcode_s     = ir_r[6:0];
    // An ack only counts while our own request is up.
    assign fetch_done_s = (state_r == ST_FETCH) && imem_req_r && bus.imem_ack;
    assign mem_done_s   = (state_r == ST_MEM) && dmem_req_r && bus.dmem_ack;

    core_next_pc u_next_pc (
        .pc          (pc_r),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .opcode      (opcode_s),
        .take_branch (br_taken_r),
        .next_pc     (next_pc_s),
        .auipc_sum   (auipc_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (fetch_done_s) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
`ifdef RV_TRAP_EN
                if (!opc_is_legal(opcode_s)) begin
                    state_next_s = ST_TRAP;
                end else begin
                    state_next_s = ST_EXEC;
                end
`else
                state_next_s = ST_EXEC;
`endif
            end
            ST_EXEC: begin
                if (opc_is_mem(opcode_s)) begin
                    state_next_s = ST_MEM;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_done_s) begin
                    state_next_s = ST_WB;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB:   state_next_s = ST_FETCH;
            ST_TRAP: state_next_s = ST_TRAP;
            default: state_next_s = ST_FETCH;
        endcase
    end

    // Registered strobes follow the state being entered, so each is valid for
    // exactly the cycles spent in that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req_r <= 1'b0;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
            rf_we_r    <= 1'b0;
        end else begin
            imem_req_r <= (state_next_s == ST_FETCH);
            dmem_req_r <= (state_next_s == ST_MEM);
            dmem_we_r  <= (state_next_s == ST_MEM) && (opcode_s == OPC_STORE);
            rf_we_r    <= (state_next_s == ST_WB) && opc_writes_rd(opcode_s);
        end
    end

    // Architectural state: ir, branch flag, write-back data, pc and instret.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            ir_r       <= 32'h0000_0000;
            instret_r  <= 32'h0000_0000;
            rf_wdata_r <= 32'h0000_0000;
            br_taken_r <= 1'b0;
        end else begin
            if (fetch_done_s) begin
                ir_r <= bus.imem_rdata;
            end
            if (state_r == ST_EXEC) begin
                br_taken_r <= take_branch;
            end
            if ((state_r == ST_EXEC) && (state_next_s == ST_WB)) begin
                rf_wdata_r <= (opcode_s == OPC_AUIPC) ? auipc_s : alu_busc;
            end else if (mem_done_s && (opcode_s == OPC_LOAD)) begin
                rf_wdata_r <= bus.dmem_rdata;
            end
            if (state_r == ST_WB) begin
                pc_r      <= next_pc_s;
                instret_r <= instret_r + 32'd1;
            end
        end
    end

`ifdef RV_TRAP_EN
    logic trap_r;

    // Halt flag, set once the sequencer parks in TRAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_r <= 1'b0;
        end else begin
            trap_r <= (state_next_s == ST_TRAP);
        end
    end

    assign trap = trap_r;
`else
    assign trap = 1'b0;
`endif

    assign bus.imem_req = imem_req_r;
    assign bus.dmem_req = dmem_req_r;
    assign bus.dmem_we  = dmem_we_r;
    assign pc           = pc_r;
    assign ir           = ir_r;
    assign instret      = instret_r;
    assign rf_we        = rf_we_r;
    assign rf_wdata     = rf_wdata_r;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed-vector bench for core_ctrl: a cycle-level memory responder plus
// hand-computed pc / write-back / instret expectations.
module tb_core_ctrl;
    import core_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] alu_busc;
    logic        take_branch;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] instret;
    logic        trap;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_ret = 0;

    core_ctrl_if bus_if ();

    core_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .pc          (pc),
        .ir          (ir),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .alu_busc    (alu_busc),
        .take_branch (take_branch),
        .rf_we       (rf_we),
        .rf_wdata    (rf_wdata),
        .instret     (instret),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting at a negedge where imem_req is high; ends at
    // the negedge where the next fetch request is visible.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] imm_v,
                             input logic [31:0] rs1_v, input logic [31:0] alu_v,
                             input logic tb_v, input int dwait, input logic [31:0] drd,
                             output int cyc, output int dreq_n, output int dwe_n,
                             output int we_n, output int we_cyc, output logic [31:0] wd);
        logic done;
        cyc = 0; dreq_n = 0; dwe_n = 0; we_n = 0; we_cyc = 0; wd = 32'h0; done = 1'b0;
        imm = imm_v; rs1_val = rs1_v; alu_busc = alu_v; take_branch = tb_v;
        for (int k = 0; k < 40; k++) begin
            if (cyc > 0 && bus_if.imem_req) begin
                done = 1'b1;
                break;
            end
            cyc++;
            bus_if.imem_ack   = bus_if.imem_req;
            bus_if.imem_rdata = instr;
            if (bus_if.dmem_req) begin
                dreq_n++;
                if (bus_if.dmem_we) dwe_n++;
                bus_if.dmem_ack   = (dreq_n == dwait);
                bus_if.dmem_rdata = drd;
            end else begin
                bus_if.dmem_ack = 1'b0;
            end
            if (rf_we) begin
                we_n++;
                we_cyc = cyc;
                wd = rf_wdata;
            end
            @(negedge clk);
        end
        bus_if.imem_ack = 1'b0;
        bus_if.dmem_ack = 1'b0;
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL instr_bound: no next fetch within 40 cycles, ir=%h", instr);
        end
    endtask

    task automatic exec_chk(input string tag, input logic [31:0] instr, input logic [31:0] imm_v,
                            input logic [31:0] rs1_v, input logic [31:0] alu_v, input logic tb_v,
                            input int dwait, input logic [31:0] drd,
                            input int exp_cyc, input int exp_dreq, input int exp_dwe,
                            input logic exp_we, input logic [31:0] exp_wd, input logic [31:0] exp_pc);
        int cyc, dreq_n, dwe_n, we_n, we_cyc;
        logic [31:0] wd;
        run_instr(instr, imm_v, rs1_v, alu_v, tb_v, dwait, drd, cyc, dreq_n, dwe_n, we_n, we_cyc, wd);
        exp_ret++;
        check_eq({tag, "_cycles"}, cyc, exp_cyc);
        check_eq({tag, "_dreq"}, dreq_n, exp_dreq);
        check_eq({tag, "_dwe"}, dwe_n, exp_dwe);
        check_eq({tag, "_rfwe"}, we_n, exp_we ? 32'd1 : 32'd0);
        if (exp_we) begin
            check_eq({tag, "_wdata"}, wd, exp_wd);
            check_eq({tag, "_we_cyc"}, we_cyc, exp_cyc);
        end
        check_eq({tag, "_pc"}, pc, exp_pc);
        check_eq({tag, "_instret"}, instret, exp_ret);
        check_eq({tag, "_ir"}, ir, instr);
        check_eq({tag, "_trap"}, trap, 1'b0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
        @(negedge clk);
    endtask

    initial begin
        logic seen_req;
        rst = 1'b1;
        imm = 32'h0; rs1_val = 32'h0; alu_busc = 32'h0; take_branch = 1'b0;
        bus_if.imem_ack = 1'b0; bus_if.imem_rdata = 32'h0;
        bus_if.dmem_ack = 1'b0; bus_if.dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);

        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_ir", ir, 32'h0);
        check_eq("rst_instret", instret, 32'h0);
        check_eq("rst_imem_req", bus_if.imem_req, 1'b0);
        check_eq("rst_dmem_req", bus_if.dmem_req, 1'b0);
        check_eq("rst_dmem_we", bus_if.dmem_we, 1'b0);
        check_eq("rst_rf_we", rf_we, 1'b0);
        check_eq("rst_rf_wdata", rf_wdata, 32'h0);
        check_eq("rst_trap", trap, 1'b0);

        rst = 1'b0;
        @(negedge clk);
        check_eq("first_fetch_req", bus_if.imem_req, 1'b1);

        //        tag       instr          imm            rs1           alu           tb    dw  drd            cyc dreq dwe we    wdata          pc
        exec_chk("addi",   32'h0050_0093, 32'h0000_0005, 32'h0,        32'h0000_0005, 1'b0, 1, 32'h0,        4,  0,   0, 1'b1, 32'h0000_0005, 32'h0000_0004);
        exec_chk("lw",     32'h0000_a103, 32'h0,        32'h0,        32'h0000_0040, 1'b0, 3, 32'hDEAD_BEEF, 7,  3,   0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0008);
        exec_chk("sw",     32'h0020_a023, 32'h0,        32'h0,        32'h0000_0044, 1'b0, 1, 32'h0,        5,  1,   1, 1'b0, 32'h0,        32'h0000_000C);
        exec_chk("jal1",   32'h0000_006f, 32'h0000_00F4, 32'h0,        32'h0000_0010, 1'b0, 1, 32'h0,        4,  0,   0, 1'b1, 32'h0000_0010, 32'h0000_0100);
        exec_chk("beq_t",  32'h0000_0063, 32'hFFFF_FFF8, 32'h0,        32'h0,        1'b1, 1, 32'h0,        4,  0,   0, 1'b0, 32'h0,        32'h0000_00F8);
        exec_chk("jal2",   32'h0000_006f, 32'h0000_0008, 32'h0,        32'h0000_00FC, 1'b0, 1, 32'h0,        4,  0,   0, 1'b1, 32'h0000_00FC, 32'h0000_0100);
        exec_chk("beq_nt", 32'h0000_0063, 32'hFFFF_FFF8, 32'h0,        32'h0,        1'b0, 1, 32'h0,        4,  0,   0, 1'b0, 32'h0,        32'h0000_0104);
        exec_chk("jalr1",  32'h0000_8067, 32'h0,        32'h0000_0203, 32'h0000_0108, 1'b0, 1, 32'h0,        4,  0,   0, 1'b1, 32'h0000_0108, 32'h0000_0202);
        exec_chk("jalr2",  32'h0000_8067, 32'h0,        32'h0000_0011, 32'h0000_0206, 1'b0, 1, 32'h0,        4,  0,   0, 1'b1, 32'h0000_0206, 32'h0000_0010);
        exec_chk("auipc",  32'h0000_1097, 32'h0000_1000, 32'h0,        32'h0000_0BAD, 1'b0, 1, 32'h0,        4,  0,   0, 1'b1, 32'h0000_1010, 32'h0000_0014);

`ifdef RV_TRAP_EN
        begin
            int trap_cyc;
            int we_n;
            trap_cyc = 0; we_n = 0;
            imm = 32'h0; alu_busc = 32'h0;
            bus_if.imem_ack = 1'b1; bus_if.imem_rdata = 32'h0000_007F;
            for (int k = 1; k <= 10; k++) begin
                if (rf_we) we_n++;
                if (trap && trap_cyc == 0) trap_cyc = k;
                @(negedge clk);
                bus_if.imem_ack = 1'b0;
            end
            check_eq("illegal_trap", trap, 1'b1);
            check_eq("illegal_trap_cyc", trap_cyc, 32'd3);
            check_eq("illegal_pc", pc, 32'h0000_0014);
            check_eq("illegal_instret", instret, exp_ret);
            check_eq("illegal_rfwe", we_n, 32'd0);
            check_eq("illegal_imem_req", bus_if.imem_req, 1'b0);
        end
`else
        exec_chk("illegal", 32'h0000_007F, 32'h0, 32'h0, 32'h0000_0055, 1'b0, 1, 32'h0, 4, 0, 0, 1'b0, 32'h0, 32'h0000_0018);
`endif

        // Reset pulse in the middle of a load's data wait.
        reset_dut();
        check_eq("mid_fetch_req", bus_if.imem_req, 1'b1);
        bus_if.imem_ack = 1'b1; bus_if.imem_rdata = 32'h0000_a103; alu_busc = 32'h0000_0080;
        @(negedge clk);
        bus_if.imem_ack = 1'b0;
        seen_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus_if.dmem_req) begin
                seen_req = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("mid_dmem_req_seen", seen_req, 1'b1);
        @(negedge clk);
        check_eq("mid_dmem_req_wait", bus_if.dmem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_dmem_req", bus_if.dmem_req, 1'b0);
        check_eq("mid_rst_pc", pc, 32'h0);
        check_eq("mid_rst_instret", instret, 32'h0);
        check_eq("mid_rst_rf_we", rf_we, 1'b0);
        check_eq("mid_rst_ir", ir, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_refetch_req", bus_if.imem_req, 1'b1);
        check_eq("mid_refetch_dreq", bus_if.dmem_req, 1'b0);
        exec_chk("addi2", 32'h0050_0093, 32'h0000_0005, 32'h0, 32'h0000_0005, 1'b0, 1, 32'h0, 4, 0, 0, 1'b1, 32'h0000_0005, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle sequencer for the RV32I core. It owns the PC, the instruction register and the retired-instruction counter. It steps each instruction through FETCH → DECODE → EXEC → MEM → WB, driving the combinational ALU, register-file write enable and data-memory handshake. It sits between the instruction/data memory ports and the ALU/register file, and is the only block that changes PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request; address is pc.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- pc  out  32  current instruction address.
- ir  out  32  instruction register; opcode = ir[6:0], funct3 = ir[14:12].
- imm  in  32  decoded immediate for ir, from the immediate generator.
- rs1_val  in  32  register-file read of ir rs1.
- alu_busc  in  32  ALU result; also the load/store address.
- take_branch  in  1  ALU branch-condition flag.
- dmem_req  out  1  data access request; address = alu_busc.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req = 1.
- dmem_ack  in  1  data access complete; dmem_rdata valid this cycle.
- dmem_rdata  in  32  load data.
- rf_we  out  1  register-file write strobe, one cycle.
- rf_wdata  out  32  write-back data.
- instret  out  32  retired-instruction count.
- trap  out  1  illegal-opcode halt; only with RV_TRAP_EN.

## Operation
States:
- FETCH
  - Asserts imem_req.
  - On imem_ack, latch ir ← imem_rdata and go to DECODE.
- DECODE
  - One cycle; register file and immediate settle.
  - Go to EXEC, or TRAP for an illegal opcode when RV_TRAP_EN is defined.
- EXEC
  - One cycle; ALU output settles and is registered.
  - LOAD/STORE go to MEM; all other opcodes go to WB.
- MEM
  - Assert dmem_req, with dmem_we = 1 for STORE.
  - On dmem_ack, capture dmem_rdata for loads and go to WB.
- WB
  - One cycle.
  - Update pc, increment instret and pulse rf_we when the opcode writes rd.
  - Go to FETCH.
- TRAP
  - Terminal; trap = 1.
  - Only rst exits this state.

Write-back:
- rf_we = 1 in WB for OP, OP_IMM, LUI, AUIPC, JAL, JALR and LOAD.
- rf_we = 0 for BRANCH and STORE.
- rf_wdata:
  - LOAD: captured load data.
  - AUIPC: pc + imm, computed here.
  - Otherwise: registered alu_busc.

Next PC, computed in WB (all arithmetic mod 2^32, so wrap-around is silent):
- JAL: pc + imm.
- JALR: (rs1_val + imm) & ~32'd1.
- BRANCH with take_branch sampled in EXEC: pc + imm.
- Otherwise: pc + 4.

Other rules:
- Misaligned targets are not checked.
- instret wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values:
  - pc = RESET_PC, ir = 0, instret = 0.
  - imem_req = dmem_req = dmem_we = rf_we = trap = 0, rf_wdata = 0.
  - State = FETCH. imem_req rises in the first cycle after rst deasserts.
- Handshakes:
  - req stays high and address stable until the ack cycle. req drops the cycle after ack.
  - An ack arriving while req = 0 is ignored.
  - An ack in the same cycle req first rises is accepted.
- Latency with zero-wait memory (ack in first req cycle):
  - ALU, branch and jump instructions: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD/STORE: 5 cycles.
  - Each memory wait cycle adds one.
- rst asserted mid-instruction:
  - All outputs return to reset values immediately.
  - Any outstanding request is abandoned; the memory must tolerate req dropping without ack.
  - No partial write-back occurs.

## Configuration
- RV_TRAP_EN defined:
  - Legal opcodes are exactly the `util.v` opcode macros.
  - Any other opcode goes DECODE → TRAP, with trap = 1 from the next cycle.
  - pc freezes at the faulting address and instret does not increment.
- RV_TRAP_EN undefined:
  - The trap port still exists, tied to 0.
  - An illegal opcode executes as a NOP: rf_we = 0, pc + 4, instret increments.

## Structure
- Opcode constants come from the shared `util.v`: OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE.
- The state encoding (3-bit localparams) also goes in `util.v`, so the bench can probe the state.
- Natural sub-module: core_next_pc, the combinational next-PC/AUIPC adder unit. Everything else lives in core_ctrl.

## Test plan
- Reset, zero-wait memory, ir = ADDI x1,x0,5, alu_busc = 5 → rf_we pulses in cycle 4 with rf_wdata = 5; pc = 4; instret = 1.
- LW with dmem_ack delayed 3 cycles, dmem_rdata = 32'hDEADBEEF → dmem_req high 3 cycles with dmem_we = 0; rf_wdata = DEADBEEF; 7 cycles total.
- BEQ at pc = 0x100, imm = -8:
  - take_branch = 1 → pc = 0xF8.
  - take_branch = 0 → pc = 0x104.
  - rf_we = 0 in both cases.
- JALR with rs1_val = 0x203, imm = 0 → pc = 0x202. AUIPC at pc = 0x10 with imm = 0x1000 → rf_wdata = 0x1010.
- rst pulsed during a MEM wait → dmem_req falls the same cycle, pc = RESET_PC, instret unchanged from 0, and a fresh fetch follows.
- Opcode 7'h7F:
  - With RV_TRAP_EN: trap = 1, pc and instret frozen.
  - Without RV_TRAP_EN: trap = 0, pc + 4, no register write.
